// File: rtl/i2s_out_tdm_if.sv
// Filter-to-serialiser word handshake.
// The filter drives rts/data; the output stage answers with rtr.
interface i2s_out_tdm_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  filt_rts;
  logic [DATA_WIDTH-1:0] filt_data;
  logic                  filt_rtr;

  modport master (
    output filt_rts,
    output filt_data,
    input  filt_rtr
  );

  modport slave (
    input  filt_rts,
    input  filt_data,
    output filt_rtr
  );
endinterface

// File: rtl/i2s_out_tdm.sv
// I2S / left-justified / TDM output stage with a word FIFO.
// Frames are all-or-nothing so channel alignment survives underruns.
module i2s_out_tdm #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int NUM_CH     = 2,
  parameter int FIFO_AW    = 3,
  parameter int LJ_MODE    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sck_transition,
  i2s_out_tdm_if.slave       filt,
  output logic               i2so_ws,
  output logic               i2so_sd,
  output logic [FIFO_AW:0]   ro_fifo_level,
  output logic               ro_fifo_underrun,
  input  logic               trig_fifo_underrun,
  output logic               ro_fifo_overrun,
  input  logic               trig_fifo_overrun
);

  localparam int FRAME = NUM_CH * SLOT_WIDTH;
  localparam int BCW   = $clog2(FRAME);
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [BCW-1:0] FRAME_M1 = BCW'(FRAME - 1);
  localparam logic [BCW-1:0] SLOT_W   = BCW'(SLOT_WIDTH);
  localparam logic [BCW-1:0] BC_ONE   = BCW'(1);

  localparam logic [FIFO_AW:0] NCH_L   = (FIFO_AW + 1)'(NUM_CH);
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]    wptr;
  logic [FIFO_AW-1:0]    rptr;

  logic full;
  logic push;
  logic drop;
  logic pop;

  logic [BCW-1:0]        bc;
  logic                  fv;
  logic [DATA_WIDTH-1:0] sh;

  logic [BCW-1:0]        bc_n;
  logic [BCW-1:0]        p;
  logic [BCW-1:0]        k;
  logic                  start;
  logic                  enough;
  logic                  fv_n;
  logic                  ws_n;
  logic                  mute;
  logic [DATA_WIDTH-1:0] cur;

  assign full          = (ro_fifo_level == DEPTH_L);
  assign filt.filt_rtr = !full;
  assign push          = filt.filt_rts & !full;
  assign drop          = filt.filt_rts & full;

  // Next bit position, frame decision and the word feeding this bit.
  always_comb begin
    bc_n   = (bc == FRAME_M1) ? '0 : bc + BC_ONE;
    p      = bc_n;
    if (LJ_MODE == 0) begin
      p = (bc_n == '0) ? FRAME_M1 : bc_n - BC_ONE;
    end
    k      = p % SLOT_W;
    start  = (p == '0);
    enough = (ro_fifo_level >= NCH_L);
    fv_n   = start ? enough : fv;
    pop    = sck_transition & fv_n & (k == '0);
    mute   = sck_transition & start & !enough;
    cur    = '0;
    if (pop) begin
      cur = mem[rptr];
    end else if (fv_n) begin
      cur = sh;
    end
    ws_n = 1'b0;
    if (NUM_CH == 2) begin
      ws_n = (bc_n >= SLOT_W);
    end else if (LJ_MODE != 0) begin
      ws_n = (bc_n == '0);
    end else begin
      ws_n = (bc_n == FRAME_M1);
    end
  end

  // Serialiser: bit counter, frame-valid state and MSB-first shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bc      <= '0;
      fv      <= 1'b0;
      sh      <= '0;
      i2so_ws <= 1'b0;
      i2so_sd <= 1'b0;
    end else if (sck_transition) begin
      bc      <= bc_n;
      fv      <= fv_n;
      sh      <= cur << 1;
      i2so_ws <= ws_n;
      i2so_sd <= cur[DATA_WIDTH-1];
    end
  end

  // FIFO storage; contents need no reset, pointers guard them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= filt.filt_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      ro_fifo_level <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   ro_fifo_level <= ro_fifo_level + 1'b1;
        2'b01:   ro_fifo_level <= ro_fifo_level - 1'b1;
        default: ro_fifo_level <= ro_fifo_level;
      endcase
    end
  end

  // Sticky status; a new event beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ro_fifo_underrun <= 1'b0;
      ro_fifo_overrun  <= 1'b0;
    end else begin
      if (mute) begin
        ro_fifo_underrun <= 1'b1;
      end else if (trig_fifo_underrun) begin
        ro_fifo_underrun <= 1'b0;
      end
      if (drop) begin
        ro_fifo_overrun <= 1'b1;
      end else if (trig_fifo_overrun) begin
        ro_fifo_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_out_tdm.sv
// Bench for i2s_out_tdm: stereo I2S instance plus a 4-ch LJ TDM instance.
// Expected (ws,sd) bits are queued at stimulus time and popped per SCK bit.
module tb_i2s_out_tdm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sck = 1'b0;

  logic       ws_a, sd_a, un_a, ov_a;
  logic       tru_a = 1'b0, tro_a = 1'b0;
  logic [3:0] lvl_a;
  logic       ws_b, sd_b, un_b, ov_b;
  logic       tru_b = 1'b0, tro_b = 1'b0;
  logic [3:0] lvl_b;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0] qa[$];
  logic [1:0] qb[$];

  i2s_out_tdm_if #(.DATA_WIDTH(24)) if_a ();
  i2s_out_tdm_if #(.DATA_WIDTH(16)) if_b ();

  i2s_out_tdm u_dut (
    .clk(clk), .rst(rst), .sck_transition(sck),
    .filt(if_a),
    .i2so_ws(ws_a), .i2so_sd(sd_a),
    .ro_fifo_level(lvl_a),
    .ro_fifo_underrun(un_a), .trig_fifo_underrun(tru_a),
    .ro_fifo_overrun(ov_a), .trig_fifo_overrun(tro_a)
  );

  i2s_out_tdm #(
    .DATA_WIDTH(16), .SLOT_WIDTH(16), .NUM_CH(4),
    .FIFO_AW(3), .LJ_MODE(1)
  ) u_tdm (
    .clk(clk), .rst(rst), .sck_transition(sck),
    .filt(if_b),
    .i2so_ws(ws_b), .i2so_sd(sd_b),
    .ro_fifo_level(lvl_b),
    .ro_fifo_underrun(un_b), .trig_fifo_underrun(tru_b),
    .ro_fifo_overrun(ov_b), .trig_fifo_overrun(tro_b)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One stereo I2S frame, 32-bit slots, 24-bit words, SD one bit late.
  task automatic exp_i2s(bit v, logic [23:0] w0, logic [23:0] w1);
    logic [23:0] wd;
    for (int t = 1; t <= 64; t++) begin
      int bcv = t % 64;
      int pv  = t - 1;
      int kv  = pv % 32;
      logic ws, sd;
      wd = (pv >= 32) ? w1 : w0;
      ws = (bcv >= 32);
      sd = (v && kv < 24) ? wd[23-kv] : 1'b0;
      qa.push_back({ws, sd});
    end
  endtask

  // One 4-slot LJ TDM frame, 16-bit slots fully used.
  task automatic exp_tdm(logic [15:0] w0, logic [15:0] w1,
                         logic [15:0] w2, logic [15:0] w3);
    logic [15:0] wd;
    for (int pv = 0; pv < 64; pv++) begin
      case (pv / 16)
        0:       wd = w0;
        1:       wd = w1;
        2:       wd = w2;
        default: wd = w3;
      endcase
      qb.push_back({pv == 0, wd[15 - (pv % 16)]});
    end
  endtask

  // n SCK pulses, one idle clk between; optional underrun clear on pulse 1.
  task automatic run(int n, bit ca, bit cb, bit tu);
    logic [1:0] e;
    for (int i = 0; i < n; i++) begin
      sck   = 1'b1;
      tru_a = tu && (i == 0);
      @(negedge clk);
      sck   = 1'b0;
      tru_a = 1'b0;
      if (ca) begin
        if (qa.size() == 0) chk("qa_empty", 1, 0);
        else begin
          e = qa.pop_front();
          chk("a_ws", ws_a, e[1]);
          chk("a_sd", sd_a, e[0]);
        end
      end
      if (cb) begin
        if (qb.size() == 0) chk("qb_empty", 1, 0);
        else begin
          e = qb.pop_front();
          chk("b_ws", ws_b, e[1]);
          chk("b_sd", sd_b, e[0]);
        end
      end
      @(negedge clk);
      if (ca) begin
        chk("a_hold_ws", ws_a, e[1]);
        chk("a_hold_sd", sd_a, e[0]);
      end
    end
  endtask

  task automatic push_a(logic [23:0] d);
    if_a.filt_rts  = 1'b1;
    if_a.filt_data = d;
    @(negedge clk);
    if_a.filt_rts  = 1'b0;
  endtask

  task automatic push_b(logic [15:0] d);
    if_b.filt_rts  = 1'b1;
    if_b.filt_data = d;
    @(negedge clk);
    if_b.filt_rts  = 1'b0;
  endtask

  logic [23:0] w [8];

  initial begin
    if_a.filt_rts  = 1'b0;
    if_a.filt_data = '0;
    if_b.filt_rts  = 1'b0;
    if_b.filt_data = '0;

    // reset defaults
    repeat (20) @(negedge clk);
    chk("rst_ws", ws_a, 0);
    chk("rst_sd", sd_a, 0);
    chk("rst_rtr", if_a.filt_rtr, 1);
    chk("rst_lvl", lvl_a, 0);
    chk("rst_un", un_a, 0);
    chk("rst_ov", ov_a, 0);
    chk("rst_ws_b", ws_b, 0);
    chk("rst_lvl_b", lvl_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // first stereo frame
    push_a(24'hFFFF00);
    push_a(24'h00AAAA);
    chk("t2_lvl", lvl_a, 2);
    exp_i2s(1'b1, 24'hFFFF00, 24'h00AAAA);
    run(64, 1, 0, 0);
    chk("t2_lvl_end", lvl_a, 0);
    chk("t2_un", un_a, 0);

    // single word -> muted frame, then both words together
    push_a(24'h123456);
    exp_i2s(1'b0, 24'h0, 24'h0);
    run(1, 1, 0, 0);
    chk("t3_un", un_a, 1);
    chk("t3_lvl", lvl_a, 1);
    run(63, 1, 0, 0);
    chk("t3_lvl_hold", lvl_a, 1);
    push_a(24'hABCDEF);
    exp_i2s(1'b1, 24'h123456, 24'hABCDEF);
    run(64, 1, 0, 0);
    chk("t3_lvl_end", lvl_a, 0);
    tru_a = 1'b1;
    @(negedge clk);
    tru_a = 1'b0;
    chk("t3_un_clr", un_a, 0);

    // overflow: 9 pushes with no SCK
    for (int i = 0; i < 8; i++) begin
      w[i] = 24'($urandom);
      push_a(w[i]);
    end
    chk("t4_lvl8", lvl_a, 8);
    chk("t4_rtr", if_a.filt_rtr, 0);
    chk("t4_ov0", ov_a, 0);
    push_a(24'hDEAD01);
    chk("t4_ov1", ov_a, 1);
    chk("t4_lvl_full", lvl_a, 8);
    tro_a = 1'b1;
    @(negedge clk);
    tro_a = 1'b0;
    chk("t4_ov_clr", ov_a, 0);
    for (int i = 0; i < 8; i += 2) exp_i2s(1'b1, w[i], w[i+1]);
    run(256, 1, 0, 0);
    chk("t4_lvl0", lvl_a, 0);
    chk("t4_un0", un_a, 0);
    exp_i2s(1'b0, 24'h0, 24'h0);
    run(64, 1, 0, 0);
    chk("t4_un1", un_a, 1);

    // clear racing a fresh muted-frame decision
    exp_i2s(1'b0, 24'h0, 24'h0);
    run(64, 1, 0, 1);
    chk("t5_un_kept", un_a, 1);

    // TDM instance, fresh reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_rst_lvl", lvl_b, 0);
    chk("t6_rst_un_a", un_a, 0);
    rst = 1'b0;
    @(negedge clk);
    push_b(16'h1111);
    push_b(16'h2222);
    push_b(16'h3333);
    push_b(16'h4444);
    chk("t6_lvl4", lvl_b, 4);
    for (int i = 1; i < 64; i++) qb.push_back(2'b00);
    exp_tdm(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    run(127, 0, 1, 0);
    chk("t6_lvl0", lvl_b, 0);
    chk("t6_ov", ov_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
